// File: rtl/frame_ram_arbiter_if.sv
// Request, read-return, swap-control and frame-RAM signals of frame_ram_arbiter.
// slave = arbiter side; master = display/host/sequencer/RAM side.
interface frame_ram_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 24
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic              swap_req;
    logic              frame_sync;
    logic              swap_done;
    logic              front_bank;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W:0]   ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  disp_req, disp_addr,
        output disp_gnt, disp_rvalid, disp_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        input  swap_req, frame_sync,
        output swap_done, front_bank,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output disp_req, disp_addr,
        input  disp_gnt, disp_rvalid, disp_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        output swap_req, frame_sync,
        input  swap_done, front_bank,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/frame_ram_arbiter.sv
// Shares the single-port double-buffered frame RAM between display reads (front bank) and host access (back bank).
// Latency: grant combinational in the request cycle; read data and rvalid one cycle after the grant.
// Backpressure: requesters hold req until gnt; display has priority, host wins after MAX_STARVE consecutive display grants.
module frame_ram_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 24,
    parameter int MAX_STARVE = 8
) (
    input  logic                  clk_25MHz,
    input  logic                  rst_n,
    frame_ram_arbiter_if.slave    bus
);

    localparam logic [7:0] STARVE_LIM = 8'(MAX_STARVE);

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W:0]   addr;
        logic [DATA_W-1:0] wdata;
    } ram_cmd_t;

    typedef struct packed {
        logic disp_read;
        logic host_read;
    } rd_tag_t;

    typedef enum logic {
        S_IDLE,
        S_PENDING
    } swap_state_t;

    swap_state_t swap_state, swap_state_nxt;
    logic        swap_fire;
    logic        front_bank;
    logic        swap_done;
    logic [7:0]  starve_cnt;
    rd_tag_t     rd_tag;

    logic        host_win;
    logic        disp_win;
    logic        disp_gnt;
    logic        host_gnt;
    ram_cmd_t    ram_cmd;

    // Arbitration: display first unless the host has waited out its starvation budget.
    always_comb begin
        host_win = bus.host_req && (!bus.disp_req || (starve_cnt == STARVE_LIM));
        disp_win = bus.disp_req && !host_win;
        disp_gnt = rst_n && disp_win;
        host_gnt = rst_n && host_win;
    end

    // Bank is chosen at issue from the current front_bank, so in-flight reads ignore a later swap.
    always_comb begin
        ram_cmd = '0;
        if (disp_gnt) begin
            ram_cmd.en   = 1'b1;
            ram_cmd.addr = {front_bank, bus.disp_addr};
        end else if (host_gnt) begin
            ram_cmd.en    = 1'b1;
            ram_cmd.we    = bus.host_we;
            ram_cmd.addr  = {~front_bank, bus.host_addr};
            ram_cmd.wdata = bus.host_wdata;
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!bus.host_req || host_win) begin
            starve_cnt <= '0;
        end else if (disp_win) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            rd_tag <= '0;
        end else begin
            rd_tag.disp_read <= disp_win;
            rd_tag.host_read <= host_win && !bus.host_we;
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            swap_state <= S_IDLE;
        end else begin
            swap_state <= swap_state_nxt;
        end
    end

    // A swap requested on the frame_sync cycle itself is applied at once; extra requests while pending are dropped.
    always_comb begin
        swap_state_nxt = swap_state;
        swap_fire      = 1'b0;
        case (swap_state)
            S_IDLE: begin
                if (bus.swap_req) begin
                    if (bus.frame_sync) begin
                        swap_fire = 1'b1;
                    end else begin
                        swap_state_nxt = S_PENDING;
                    end
                end
            end
            S_PENDING: begin
                if (bus.frame_sync) begin
                    swap_fire      = 1'b1;
                    swap_state_nxt = S_IDLE;
                end
            end
            default: swap_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            front_bank <= 1'b0;
            swap_done  <= 1'b0;
        end else begin
            front_bank <= front_bank ^ swap_fire;
            swap_done  <= swap_fire;
        end
    end

    assign bus.disp_gnt    = disp_gnt;
    assign bus.host_gnt    = host_gnt;
    assign bus.disp_rvalid = rd_tag.disp_read;
    assign bus.host_rvalid = rd_tag.host_read;
    assign bus.disp_rdata  = bus.ram_rdata;
    assign bus.host_rdata  = bus.ram_rdata;
    assign bus.swap_done   = swap_done;
    assign bus.front_bank  = front_bank;
    assign bus.ram_en      = ram_cmd.en;
    assign bus.ram_we      = ram_cmd.we;
    assign bus.ram_addr    = ram_cmd.addr;
    assign bus.ram_wdata   = ram_cmd.wdata;

    grant_mutex_a: assert property (@(posedge clk_25MHz) disable iff (!rst_n)
        !(disp_gnt && host_gnt));

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter with a behavioural two-bank frame RAM.
module tb_frame_ram_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 24;

    logic clk_25MHz = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    frame_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    frame_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STARVE(8)) dut (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_n),
        .bus       (bus.slave)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    // Frame RAM model: unwritten words read a fixed per-address pattern.
    bit [DATA_W-1:0] mem [0:4095];
    bit [4095:0]     written;

    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W:0] a);
        if (a == 12'h005)      return 24'hABCDEF;
        else if (a == 12'h040) return 24'h111111;
        else                   return {12'h000, a};
    endfunction

    always @(posedge clk_25MHz) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                mem[bus.ram_addr]     <= bus.ram_wdata;
                written[bus.ram_addr] <= 1'b1;
            end
            bus.ram_rdata <= written[bus.ram_addr] ? mem[bus.ram_addr] : init_word(bus.ram_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        logic exp_host;

        rst_n           = 1'b0;
        bus.disp_req    = 1'b1;
        bus.disp_addr   = '0;
        bus.host_req    = 1'b1;
        bus.host_we     = 1'b0;
        bus.host_addr   = '0;
        bus.host_wdata  = '0;
        bus.swap_req    = 1'b0;
        bus.frame_sync  = 1'b0;
        bus.ram_rdata   = '0;

        // Reset state with both requests asserted
        #5;
        check("rst_disp_gnt", bus.disp_gnt, 0);
        check("rst_host_gnt", bus.host_gnt, 0);
        check("rst_ram_en", bus.ram_en, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_front", bus.front_bank, 0);
        check("rst_swap_done", bus.swap_done, 0);
        check("rst_disp_rvalid", bus.disp_rvalid, 0);
        bus.disp_req = 1'b0;
        bus.host_req = 1'b0;
        tick();
        #10 rst_n = 1'b1;
        tick();

        // Display read of bank 0 word 0x005
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h005;
        #1;
        check("rd_disp_gnt", bus.disp_gnt, 1);
        check("rd_host_gnt", bus.host_gnt, 0);
        check("rd_ram_en", bus.ram_en, 1);
        check("rd_ram_we", bus.ram_we, 0);
        check("rd_ram_addr", bus.ram_addr, 12'h005);
        tick();
        bus.disp_req = 1'b0;
        check("rd_disp_rvalid", bus.disp_rvalid, 1);
        check("rd_disp_rdata", bus.disp_rdata, 24'hABCDEF);
        check("rd_host_rvalid", bus.host_rvalid, 0);
        #1;
        check("idle_ram_en", bus.ram_en, 0);
        tick();
        check("rd_rvalid_one_cycle", bus.disp_rvalid, 0);

        // Host write goes to back bank 1
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 11'h040;
        bus.host_wdata = 24'h123456;
        #1;
        check("wr_host_gnt", bus.host_gnt, 1);
        check("wr_ram_we", bus.ram_we, 1);
        check("wr_ram_addr", bus.ram_addr, 12'h840);
        check("wr_ram_wdata", bus.ram_wdata, 24'h123456);
        tick();
        bus.host_req = 1'b0;
        bus.host_we  = 1'b0;
        check("wr_no_rvalid", bus.host_rvalid, 0);

        // Display still sees bank 0 at 0x040
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h040;
        #1;
        check("front_rd_addr", bus.ram_addr, 12'h040);
        tick();
        bus.disp_req = 1'b0;
        check("front_rd_rvalid", bus.disp_rvalid, 1);
        check("front_rd_rdata", bus.disp_rdata, 24'h111111);

        // Host reads back its own write
        bus.host_req  = 1'b1;
        bus.host_addr = 11'h040;
        #1;
        check("host_rd_addr", bus.ram_addr, 12'h840);
        tick();
        bus.host_req = 1'b0;
        check("host_rd_rvalid", bus.host_rvalid, 1);
        check("host_rd_disp_rvalid", bus.disp_rvalid, 0);
        check("host_rd_rdata", bus.host_rdata, 24'h123456);
        tick();

        // Starvation guard: 8 display grants then 1 host grant, repeating
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h001;
        bus.host_req  = 1'b1;
        bus.host_addr = 11'h007;
        wait_cnt      = 0;
        #1;
        for (int i = 0; i < 30; i++) begin
            exp_host = ((i % 9) == 8);
            check($sformatf("starve_host_gnt[%0d]", i), bus.host_gnt, exp_host);
            check($sformatf("starve_disp_gnt[%0d]", i), bus.disp_gnt, !exp_host);
            wait_cnt = bus.host_gnt ? 0 : wait_cnt + 1;
            check($sformatf("starve_wait[%0d]", i), wait_cnt <= 8, 1);
            tick();
        end
        bus.disp_req = 1'b0;
        bus.host_req = 1'b0;
        tick();

        // Deferred swap: request now, frame_sync five cycles later
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        repeat (4) tick();
        bus.frame_sync = 1'b1;
        #1;
        check("swap_front_before", bus.front_bank, 0);
        check("swap_done_before", bus.swap_done, 0);
        tick();
        bus.frame_sync = 1'b0;
        check("swap_done_pulse", bus.swap_done, 1);
        check("swap_front_after", bus.front_bank, 1);
        tick();
        check("swap_done_one_cycle", bus.swap_done, 0);

        // After the swap host targets bank 0 and display reads bank 1
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 11'h001;
        bus.host_wdata = 24'h0F0F0F;
        #1;
        check("swap_host_addr", bus.ram_addr, 12'h001);
        tick();
        bus.host_req  = 1'b0;
        bus.host_we   = 1'b0;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h040;
        #1;
        check("swap_disp_addr", bus.ram_addr, 12'h840);
        tick();
        bus.disp_req = 1'b0;
        check("swap_disp_rdata", bus.disp_rdata, 24'h123456);

        // Immediate swap back to bank 0
        bus.swap_req   = 1'b1;
        bus.frame_sync = 1'b1;
        tick();
        bus.swap_req   = 1'b0;
        bus.frame_sync = 1'b0;
        check("imm_front", bus.front_bank, 0);
        check("imm_swap_done", bus.swap_done, 1);

        // Second request while pending gives a single toggle
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        tick();
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        check("pend_no_toggle", bus.front_bank, 0);
        tick();
        bus.frame_sync = 1'b1;
        bus.disp_req   = 1'b1;
        bus.disp_addr  = 11'h040;
        #1;
        check("inflight_addr", bus.ram_addr, 12'h040);
        tick();
        bus.frame_sync = 1'b0;
        bus.disp_req   = 1'b0;
        check("pend_front", bus.front_bank, 1);
        check("pend_swap_done", bus.swap_done, 1);
        check("inflight_rdata", bus.disp_rdata, 24'h111111);
        tick();
        bus.frame_sync = 1'b1;
        tick();
        bus.frame_sync = 1'b0;
        check("no_queued_front", bus.front_bank, 1);
        check("no_queued_done", bus.swap_done, 0);

        // Reset in the middle of a host read grant
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 11'h040;
        bus.disp_req  = 1'b0;
        #1;
        check("mid_host_gnt", bus.host_gnt, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_host_gnt", bus.host_gnt, 0);
        check("mid_rst_ram_en", bus.ram_en, 0);
        check("mid_rst_ram_we", bus.ram_we, 0);
        check("mid_rst_front", bus.front_bank, 0);
        bus.disp_req = 1'b1;
        #1;
        check("mid_rst_disp_gnt", bus.disp_gnt, 0);
        tick();
        check("mid_rst_host_rvalid", bus.host_rvalid, 0);
        bus.host_req = 1'b0;
        bus.disp_req = 1'b0;
        #10 rst_n = 1'b1;
        tick();
        check("post_rst_host_rvalid", bus.host_rvalid, 0);
        check("post_rst_disp_rvalid", bus.disp_rvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
